// File: rtl/lancer_pkg.sv
// Shared types, active-low segment patterns and the binary-to-decimal
// helper for the roll display.
package lancer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ROLLING = 2'd1,
        SHOW    = 2'd2
    } state_t;

    // Active-low patterns, bit 0 = segment a ... bit 6 = segment g.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] units;
        logic       err;
    } bcd_t;

    function automatic bcd_t bin2bcd(input logic [6:0] v);
        bcd_t r;
        r.tens  = 4'(v / 7'd10);
        r.units = 4'(v % 7'd10);
        r.err   = (v > 7'd99);
        return r;
    endfunction

    function automatic logic [6:0] seg_of_digit(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/lancer_affichage_anti_rebond.sv
// Roll button conditioning: 2-FF synchronizer, stable-level debouncer and
// a one-cycle pulse on each accepted rising edge.
module anti_rebond #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_press
);
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            r_sync0;
    logic            r_sync1;
    logic            r_db;
    logic            r_db_d;
    logic            r_press;
    logic [DB_W-1:0] r_cnt;

    // The count only advances while the synchronized level disagrees with
    // the accepted level; any agreement restarts the stability window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync0 <= 1'b0;
            r_sync1 <= 1'b0;
            r_db    <= 1'b0;
            r_db_d  <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync0 <= i_btn;
            r_sync1 <= r_sync0;
            if (r_sync1 != r_db) begin
                if (r_cnt == DB_LAST) begin
                    r_db  <= r_sync1;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + DB_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
            r_db_d  <= r_db;
            r_press <= r_db & ~r_db_d;
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/lancer_affichage.sv
// Dice roll controller: debounced press starts a timed rolling animation,
// then the captured value is held on a two-digit multiplexed display.
module lancer_affichage
    import lancer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ROLL_CYCLES     = 25000000,
    parameter int REFRESH_CYCLES  = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] random,
    input  logic       btn_roll,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       rolling,
    output logic [6:0] result,
    output logic       result_valid
);
    localparam int ROLL_W = (ROLL_CYCLES > 1) ? $clog2(ROLL_CYCLES) : 1;
    localparam int REF_W  = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [ROLL_W-1:0] ROLL_LAST = ROLL_W'(ROLL_CYCLES - 1);
    localparam logic [REF_W-1:0]  REF_LAST  = REF_W'(REFRESH_CYCLES - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [ROLL_W-1:0]  r_roll_cnt;
    logic [REF_W-1:0]   r_refresh;
    logic [6:0]         r_result;
    logic               r_valid;
    logic               r_rolling;
    logic               r_sel;
    logic [1:0]         r_an;
    logic [6:0]         r_seg;
    logic               w_press;
    logic               w_roll_done;
    logic               w_refresh_wrap;
    logic               w_sel_next;
    logic [6:0]         w_value;
    bcd_t               w_bcd;
    logic [6:0]         w_seg;

    anti_rebond #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_anti_rebond (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_btn  (btn_roll),
        .o_press(w_press)
    );

    always_comb begin
        w_state_next = r_state;
        w_roll_done  = (r_state == ROLLING) && (r_roll_cnt == ROLL_LAST);
        case (r_state)
            IDLE:    if (w_press) w_state_next = ROLLING;
            ROLLING: if (w_roll_done) w_state_next = SHOW;
            SHOW:    if (w_press) w_state_next = ROLLING;
            default: w_state_next = IDLE;
        endcase
    end

    // The digit select and its segment pattern are computed from the same
    // next-select value so both change on one edge.
    always_comb begin
        w_refresh_wrap = (r_refresh == REF_LAST);
        w_sel_next     = r_sel ^ w_refresh_wrap;
        w_value        = (r_state == SHOW) ? r_result : random;
        w_bcd          = bin2bcd(w_value);
        w_seg          = SEG_DASH;
        if (r_state == IDLE)
            w_seg = SEG_DASH;
        else if (w_bcd.err)
            w_seg = SEG_E;
        else if (w_sel_next)
            w_seg = (w_bcd.tens == 4'd0) ? SEG_BLANK : seg_of_digit(w_bcd.tens);
        else
            w_seg = seg_of_digit(w_bcd.units);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_roll_cnt <= '0;
            r_refresh  <= '0;
            r_result   <= '0;
            r_valid    <= 1'b0;
            r_rolling  <= 1'b0;
            r_sel      <= 1'b0;
            r_an       <= 2'b10;
            r_seg      <= SEG_DASH;
        end else begin
            r_state    <= w_state_next;
            r_rolling  <= (w_state_next == ROLLING);
            r_roll_cnt <= ((r_state == ROLLING) && !w_roll_done) ? r_roll_cnt + ROLL_W'(1) : '0;
            if (w_roll_done) begin
                r_result <= random;
                r_valid  <= 1'b1;
            end else if ((r_state == SHOW) && w_press) begin
                r_valid  <= 1'b0;
            end
            r_refresh  <= w_refresh_wrap ? '0 : r_refresh + REF_W'(1);
            r_sel      <= w_sel_next;
            r_an       <= w_sel_next ? 2'b01 : 2'b10;
            r_seg      <= w_seg;
        end
    end

    assign seg          = r_seg;
    assign an           = r_an;
    assign rolling      = r_rolling;
    assign result       = r_result;
    assign result_valid = r_valid;

endmodule

// File: tb/tb_lancer_affichage.sv
// Directed bench for lancer_affichage with short debounce/roll/refresh times.
module tb_lancer_affichage;

    localparam logic [6:0] T_SEG_0     = 7'h40;
    localparam logic [6:0] T_SEG_1     = 7'h79;
    localparam logic [6:0] T_SEG_2     = 7'h24;
    localparam logic [6:0] T_SEG_3     = 7'h30;
    localparam logic [6:0] T_SEG_5     = 7'h12;
    localparam logic [6:0] T_SEG_7     = 7'h78;
    localparam logic [6:0] T_SEG_BLANK = 7'h7F;
    localparam logic [6:0] T_SEG_DASH  = 7'h3F;
    localparam logic [6:0] T_SEG_E     = 7'h06;

    logic       clk;
    logic       rst_n;
    logic [6:0] random;
    logic       btn_roll;
    logic [6:0] seg;
    logic [1:0] an;
    logic       rolling;
    logic [6:0] result;
    logic       result_valid;

    int n_checks;
    int n_pass;

    lancer_affichage #(
        .DEBOUNCE_CYCLES(4),
        .ROLL_CYCLES    (16),
        .REFRESH_CYCLES (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .random      (random),
        .btn_roll    (btn_roll),
        .seg         (seg),
        .an          (an),
        .rolling     (rolling),
        .result      (result),
        .result_valid(result_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Holds the button high until rolling is observed (bounded).
    task automatic do_press(output bit ok);
        ok = 1'b0;
        btn_roll = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rolling === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Counts further cycles with rolling high until it falls (bounded).
    task automatic wait_roll_end(output int n_high, output bit ok);
        n_high = 0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (rolling === 1'b1) n_high++;
            else begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic get_digits(output logic [6:0] tens_seg, output logic [6:0] units_seg);
        tens_seg  = 'x;
        units_seg = 'x;
        tick();
        tick();
        for (int i = 0; i < 20; i++) begin
            tick();
            if (an === 2'b01) tens_seg = seg;
            if (an === 2'b10) units_seg = seg;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        random = 7'd0;
        btn_roll = 1'b0;
        tick();
        tick();
        tick();
        n_checks++; if (an !== 2'b10) $display("FAIL reset_an: got %b expected 10", an); else n_pass++;
        n_checks++; if (seg !== T_SEG_DASH) $display("FAIL reset_seg: got %h expected %h", seg, T_SEG_DASH); else n_pass++;
        n_checks++; if (rolling !== 1'b0) $display("FAIL reset_rolling: got %b expected 0", rolling); else n_pass++;
        n_checks++; if (result !== 7'd0) $display("FAIL reset_result: got %0d expected 0", result); else n_pass++;
        n_checks++; if (result_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", result_valid); else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_idle_refresh;
        logic [1:0] exp_an;
        for (int k = 1; k <= 40; k++) begin
            tick();
            exp_an = (((k / 8) % 2) == 1) ? 2'b01 : 2'b10;
            n_checks++; if (an !== exp_an) $display("FAIL idle_an cycle %0d: got %b expected %b", k, an, exp_an); else n_pass++;
            n_checks++; if (seg !== T_SEG_DASH) $display("FAIL idle_seg cycle %0d: got %h expected %h", k, seg, T_SEG_DASH); else n_pass++;
        end
        n_checks++; if (result_valid !== 1'b0) $display("FAIL idle_valid: got %b expected 0", result_valid); else n_pass++;
    endtask

    // Bouncing button, then a held press rolling a 57.
    task automatic test_debounce_roll57;
        bit bad_roll;
        int lat;
        int n_high;
        bit ok;
        logic [6:0] t_seg;
        logic [6:0] u_seg;
        random = 7'd57;
        bad_roll = 1'b0;
        for (int s = 0; s < 6; s++) begin
            btn_roll = ((s % 2) == 0);
            tick();
            if (rolling !== 1'b0) bad_roll = 1'b1;
            tick();
            if (rolling !== 1'b0) bad_roll = 1'b1;
        end
        n_checks++; if (bad_roll) $display("FAIL bounce_no_roll: got rolling 1 expected 0"); else n_pass++;
        btn_roll = 1'b1;
        lat = -1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (rolling === 1'b1) begin
                lat = i - 1;
                break;
            end
        end
        n_checks++; if (lat != 7) $display("FAIL press_latency: got %0d expected 7", lat); else n_pass++;
        wait_roll_end(n_high, ok);
        n_checks++; if (!ok || (n_high + 1) != 16) $display("FAIL roll57_len: got %0d (ended %0d) expected 16", n_high + 1, ok); else n_pass++;
        n_checks++; if (result !== 7'd57) $display("FAIL roll57_result: got %0d expected 57", result); else n_pass++;
        n_checks++; if (result_valid !== 1'b1) $display("FAIL roll57_valid: got %b expected 1", result_valid); else n_pass++;
        bad_roll = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rolling !== 1'b0) bad_roll = 1'b1;
        end
        n_checks++; if (bad_roll) $display("FAIL held_no_second_roll: got rolling 1 expected 0"); else n_pass++;
        get_digits(t_seg, u_seg);
        n_checks++; if (t_seg !== T_SEG_5) $display("FAIL roll57_tens: got %h expected %h", t_seg, T_SEG_5); else n_pass++;
        n_checks++; if (u_seg !== T_SEG_7) $display("FAIL roll57_units: got %h expected %h", u_seg, T_SEG_7); else n_pass++;
        btn_roll = 1'b0;
        for (int i = 0; i < 10; i++) tick();
    endtask

    task automatic test_digits;
        logic [6:0] vals[3];
        logic [6:0] exp_t[3];
        logic [6:0] exp_u[3];
        logic [6:0] t_seg;
        logic [6:0] u_seg;
        int n_high;
        bit ok;
        vals  = '{7'd3, 7'd0, 7'd110};
        exp_t = '{T_SEG_BLANK, T_SEG_BLANK, T_SEG_E};
        exp_u = '{T_SEG_3, T_SEG_0, T_SEG_E};
        for (int v = 0; v < 3; v++) begin
            random = vals[v];
            do_press(ok);
            btn_roll = 1'b0;
            n_checks++; if (!ok) $display("FAIL digits_press %0d: got no roll expected roll", vals[v]); else n_pass++;
            wait_roll_end(n_high, ok);
            n_checks++; if (result !== vals[v]) $display("FAIL digits_result: got %0d expected %0d", result, vals[v]); else n_pass++;
            get_digits(t_seg, u_seg);
            n_checks++; if (t_seg !== exp_t[v]) $display("FAIL digits_tens %0d: got %h expected %h", vals[v], t_seg, exp_t[v]); else n_pass++;
            n_checks++; if (u_seg !== exp_u[v]) $display("FAIL digits_units %0d: got %h expected %h", vals[v], u_seg, exp_u[v]); else n_pass++;
        end
    endtask

    // A second debounced press lands mid-roll and must not extend it.
    task automatic test_press_during_roll;
        int n_high;
        int n_rest;
        bit ok;
        bit bad_roll;
        random = 7'd42;
        do_press(ok);
        btn_roll = 1'b0;
        n_checks++; if (!ok) $display("FAIL midroll_press: got no roll expected roll"); else n_pass++;
        n_high = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rolling === 1'b1) n_high++;
        end
        btn_roll = 1'b1;
        wait_roll_end(n_rest, ok);
        n_high += n_rest;
        n_checks++; if (!ok || n_high != 16) $display("FAIL midroll_len: got %0d (ended %0d) expected 16", n_high, ok); else n_pass++;
        n_checks++; if (result !== 7'd42) $display("FAIL midroll_result: got %0d expected 42", result); else n_pass++;
        n_checks++; if (result_valid !== 1'b1) $display("FAIL midroll_valid: got %b expected 1", result_valid); else n_pass++;
        bad_roll = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rolling !== 1'b0) bad_roll = 1'b1;
        end
        n_checks++; if (bad_roll) $display("FAIL midroll_no_restart: got rolling 1 expected 0"); else n_pass++;
        btn_roll = 1'b0;
        for (int i = 0; i < 10; i++) tick();
    endtask

    task automatic test_press_show;
        int n_high;
        bit ok;
        logic [6:0] t_seg;
        logic [6:0] u_seg;
        n_checks++; if (result_valid !== 1'b1) $display("FAIL show_valid_before: got %b expected 1", result_valid); else n_pass++;
        random = 7'd21;
        do_press(ok);
        btn_roll = 1'b0;
        n_checks++; if (!ok) $display("FAIL show_press: got no roll expected roll"); else n_pass++;
        n_checks++; if (result_valid !== 1'b0) $display("FAIL show_valid_cleared: got %b expected 0", result_valid); else n_pass++;
        wait_roll_end(n_high, ok);
        n_checks++; if (!ok || (n_high + 1) != 16) $display("FAIL show_roll_len: got %0d expected 16", n_high + 1); else n_pass++;
        n_checks++; if (result !== 7'd21) $display("FAIL show_result: got %0d expected 21", result); else n_pass++;
        get_digits(t_seg, u_seg);
        n_checks++; if (t_seg !== T_SEG_2) $display("FAIL show_tens: got %h expected %h", t_seg, T_SEG_2); else n_pass++;
        n_checks++; if (u_seg !== T_SEG_1) $display("FAIL show_units: got %h expected %h", u_seg, T_SEG_1); else n_pass++;
    endtask

    task automatic test_reset_mid_roll;
        bit ok;
        bit bad;
        random = 7'd88;
        do_press(ok);
        btn_roll = 1'b0;
        n_checks++; if (!ok) $display("FAIL rstmid_press: got no roll expected roll"); else n_pass++;
        for (int i = 0; i < 5; i++) tick();
        rst_n = 1'b0;
        #1;
        n_checks++; if (rolling !== 1'b0) $display("FAIL rstmid_rolling: got %b expected 0", rolling); else n_pass++;
        n_checks++; if (result !== 7'd0) $display("FAIL rstmid_result: got %0d expected 0", result); else n_pass++;
        n_checks++; if (result_valid !== 1'b0) $display("FAIL rstmid_valid: got %b expected 0", result_valid); else n_pass++;
        n_checks++; if (an !== 2'b10) $display("FAIL rstmid_an: got %b expected 10", an); else n_pass++;
        n_checks++; if (seg !== T_SEG_DASH) $display("FAIL rstmid_seg: got %h expected %h", seg, T_SEG_DASH); else n_pass++;
        tick();
        tick();
        rst_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rolling !== 1'b0 || result_valid !== 1'b0 || seg !== T_SEG_DASH) bad = 1'b1;
        end
        n_checks++; if (bad) $display("FAIL rstmid_stays_idle: got activity expected idle dash"); else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_idle_refresh();
        test_debounce_roll57();
        test_digits();
        test_press_during_roll();
        test_press_show();
        test_reset_mid_roll();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
